sha3_pad_packer: RTL

- Upstream feeder for the AXI_SHA core.
- Accepts a raw 16-bit AXI-Stream message with byte-granular end (TKEEP, TLAST).
- Emits rate-sized blocks of 16-bit words with SHA3 pad10*1 padding already applied, so the core only absorbs and permutes.
- Marks the end of every rate block, and flags which block is the final one of the message.

---
 rtl/sha3_pad_packer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sha3_pad_packer.sv
// SHA3 pad10*1 packer: turns a byte-granular 16-bit message stream into
// rate-sized blocks of 16-bit words with the domain suffix and final 0x80 applied.
module sha3_pad_packer #(
    parameter int         WIDTH  = 16,
    parameter logic [7:0] DOMAIN = 8'h06
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic [1:0]       s_tkeep,
    input  logic [1:0]       s_tuser,
    input  logic             s_tlast,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic [1:0]       m_tuser,
    output logic             m_tlast,
    output logic             m_tid,
    output logic             m_tvalid,
    input  logic             m_tready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [6:0]       r_wcnt;
    logic             r_pad_first;
    logic [WIDTH-1:0] r_m_tdata;
    logic [1:0]       r_m_tuser;
    logic             r_m_tlast;
    logic             r_m_tid;
    logic             r_m_tvalid;

    logic [1:0]       w_mode;
    logic             w_rate_last;
    logic             w_out_free;
    logic             w_in_hs;
    logic             w_load;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_word;
    logic             w_final;
    state_t           w_state_nxt;
    logic             w_pad_first_nxt;

    // Rate of the sponge in 16-bit words for each digest size.
    function automatic logic [6:0] rate_words(input logic [1:0] mode);
        case (mode)
            2'd0:    return 7'd72;
            2'd1:    return 7'd68;
            2'd2:    return 7'd52;
            2'd3:    return 7'd36;
            default: return 7'd72;
        endcase
    endfunction

    // Handshake qualifiers; the output register is free when empty or draining.
    always_comb begin
        w_out_free = !r_m_tvalid || m_tready;
        w_in_hs    = s_tvalid && s_tready;
        if (r_state == ST_PAD) begin
            w_load = w_out_free;
        end else begin
            w_load = w_in_hs;
        end
    end

    assign s_tready = ARESETn && (r_state != ST_PAD) && w_out_free;

    // Next output word, block-final flag and next state for the word being loaded.
    always_comb begin
        // In IDLE the beat being accepted opens a message, so its own tuser rules.
        if (r_state == ST_IDLE) begin
            w_mode = s_tuser;
        end else begin
            w_mode = r_mode;
        end
        w_rate_last     = (r_wcnt == (rate_words(w_mode) - 7'd1));
        w_base          = s_tdata;
        w_word          = s_tdata;
        w_final         = 1'b0;
        w_state_nxt     = ST_DATA;
        w_pad_first_nxt = 1'b0;
        if (r_state == ST_PAD) begin
            if (r_pad_first) begin
                w_base = {8'h00, DOMAIN};
            end else begin
                w_base = 16'h0000;
            end
            if (w_rate_last) begin
                w_word      = w_base | 16'h8000;
                w_final     = 1'b1;
                w_state_nxt = ST_IDLE;
            end else begin
                w_word      = w_base;
                w_state_nxt = ST_PAD;
            end
        end else if (!s_tlast) begin
            w_word      = s_tdata;
            w_state_nxt = ST_DATA;
        end else if (s_tkeep[1]) begin
            // Full last word: the domain byte opens the following word.
            w_word          = s_tdata;
            w_state_nxt     = ST_PAD;
            w_pad_first_nxt = 1'b1;
        end else begin
            if (s_tkeep[0]) begin
                w_base = {DOMAIN, s_tdata[7:0]};
            end else begin
                w_base = {8'h00, DOMAIN};
            end
            if (w_rate_last) begin
                w_word      = w_base | 16'h8000;
                w_final     = 1'b1;
                w_state_nxt = ST_IDLE;
            end else begin
                w_word      = w_base;
                w_state_nxt = ST_PAD;
            end
        end
    end

    // Control state, word position and registered output stage.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= ST_IDLE;
            r_mode      <= 2'd0;
            r_wcnt      <= 7'd0;
            r_pad_first <= 1'b0;
            r_m_tdata   <= '0;
            r_m_tuser   <= 2'd0;
            r_m_tlast   <= 1'b0;
            r_m_tid     <= 1'b0;
            r_m_tvalid  <= 1'b0;
        end else if (w_load) begin
            if (r_state == ST_IDLE) begin
                r_mode <= s_tuser;
            end
            r_state     <= w_state_nxt;
            r_pad_first <= w_pad_first_nxt;
            r_wcnt      <= w_rate_last ? 7'd0 : (r_wcnt + 7'd1);
            r_m_tdata   <= w_word;
            r_m_tuser   <= w_mode;
            r_m_tlast   <= w_rate_last;
            r_m_tid     <= w_final;
            r_m_tvalid  <= 1'b1;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_tdata  = r_m_tdata;
    assign m_tuser  = r_m_tuser;
    assign m_tlast  = r_m_tlast;
    assign m_tid    = r_m_tid;
    assign m_tvalid = r_m_tvalid;

endmodule
